// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster generator: 640x480@60 defaults,
// derived totals and the colour-bar lookup.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_CW       = 12;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  function automatic int h_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction

  // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black
  function automatic rgb_t bar_colour(logic [2:0] idx);
    rgb_t c;
    c.r = (idx == 3'd0 || idx == 3'd1 || idx == 3'd4 || idx == 3'd5) ? 4'hF : 4'h0;
    c.g = (idx == 3'd0 || idx == 3'd1 || idx == 3'd2 || idx == 3'd3) ? 4'hF : 4'h0;
    c.b = (idx == 3'd0 || idx == 3'd2 || idx == 3'd4 || idx == 3'd6) ? 4'hF : 4'h0;
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing / colour bundle between the generator (master) and the
// pixel-colour logic plus VGA pins (slave).
interface vga_timing_gen_if #(
  parameter int CW = 12
);
  logic          pix_ce;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          de;
  logic          hsync;
  logic          vsync;
  logic          line_start;
  logic          frame_start;
  logic [11:0]   rgb_in;
  logic [3:0]    vgaRed;
  logic [3:0]    vgaGreen;
  logic [3:0]    vgaBlue;

  modport master (
    output pix_ce, x, y, de, hsync, vsync, line_start, frame_start,
    output vgaRed, vgaGreen, vgaBlue,
    input  rgb_in
  );

  modport slave (
    input  pix_ce, x, y, de, hsync, vsync, line_start, frame_start,
    input  vgaRed, vgaGreen, vgaBlue,
    output rgb_in
  );
endinterface

// File: rtl/vga_timing_gen_pixel_ce_gen.sv
// Pixel-rate clock enable: divides the system clock by CLK_DIV without
// creating a new clock. tick is the advance condition, pix_ce its registered copy.
module pixel_ce_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick,
  output logic pix_ce
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  assign tick = en && (div == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      pix_ce <= 1'b0;
    end else if (!en) begin
      div    <= '0;
      pix_ce <= 1'b0;
    end else begin
      div    <= tick ? '0 : div + 1'b1;
      pix_ce <= tick;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator on a pixel clock enable.
// Optional colour-bar source compiled in with `define VGA_PATTERN_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int CW       = DEF_CW,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pattern_sel,
  vga_timing_gen_if.master vif
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] Y_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic          tick;
  logic          pix_ce;
  logic [CW-1:0] x_q, y_q, x_n, y_n;
  logic          de_q, hs_q, vs_q, ls_q, fs_q;
  logic          de_n, hs_n, vs_n, ls_n, fs_n;
  rgb_t          colour;

  pixel_ce_gen #(.CLK_DIV(CLK_DIV)) u_ce (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .tick   (tick),
    .pix_ce (pix_ce)
  );

  // Next-state counters; every registered output decodes these so all
  // outputs change on the same edge as x/y.
  always_comb begin
    x_n = x_q;
    y_n = y_q;
    if (tick) begin
      if (x_q == X_LAST) begin
        x_n = '0;
        y_n = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_n = x_q + 1'b1;
      end
    end
  end

  always_comb begin
    de_n = (x_n < X_ACT) && (y_n < Y_ACT);
    hs_n = ((x_n >= HS_START) && (x_n < HS_END)) ? HS_POL : ~HS_POL;
    vs_n = ((y_n >= VS_START) && (y_n < VS_END)) ? VS_POL : ~VS_POL;
    ls_n = tick && (x_n == '0);
    fs_n = tick && (x_n == '0) && (y_n == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= X_LAST;
      y_q  <= Y_LAST;
      de_q <= 1'b0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else if (!en) begin
      x_q  <= X_LAST;
      y_q  <= Y_LAST;
      de_q <= 1'b0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      x_q  <= x_n;
      y_q  <= y_n;
      de_q <= de_n;
      hs_q <= hs_n;
      vs_q <= vs_n;
      ls_q <= ls_n;
      fs_q <= fs_n;
    end
  end

`ifdef VGA_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [CW-1:0] bar_full;
  logic [2:0]    bar_n, bar_q;

  // Clamp keeps a non-multiple-of-8 width from wrapping back to white.
  always_comb begin
    bar_full = x_n / CW'(BAR_W);
    bar_n    = (bar_full > CW'(7)) ? 3'd7 : bar_full[2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   bar_q <= 3'd0;
    else if (!en) bar_q <= 3'd0;
    else          bar_q <= bar_n;
  end

  assign colour = pattern_sel ? bar_colour(bar_q) : rgb_t'(vif.rgb_in);
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign colour = rgb_t'(vif.rgb_in);
`endif

  assign vif.pix_ce      = pix_ce;
  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.de          = de_q;
  assign vif.hsync       = hs_q;
  assign vif.vsync       = vs_q;
  assign vif.line_start  = ls_q;
  assign vif.frame_start = fs_q;
  assign vif.vgaRed      = de_q ? colour.r : 4'h0;
  assign vif.vgaGreen    = de_q ? colour.g : 4'h0;
  assign vif.vgaBlue     = de_q ? colour.b : 4'h0;

endmodule
